// File: rtl/mem_scan_reader_if.sv
// mem_scan_reader_if: bundles the sweep control, RAM read port and display
// outputs of the memory scan reader.
// master = the reader, slave = top level / RAM / display side.
// With MEM_SCAN_READER_PAUSE_EN defined, the bundle also carries `pause`.
interface mem_scan_reader_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          start;
    logic          continuous;
    logic [AW-1:0] a;
    logic [DW-1:0] dout;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
`ifdef MEM_SCAN_READER_PAUSE_EN
    logic          pause;

    modport master (
        input  start, continuous, dout, pause,
        output a, rd_addr, rd_data, rd_valid, busy, done, checksum
    );
    modport slave (
        output start, continuous, dout, pause,
        input  a, rd_addr, rd_data, rd_valid, busy, done, checksum
    );
`else
    modport master (
        input  start, continuous, dout,
        output a, rd_addr, rd_data, rd_valid, busy, done, checksum
    );
    modport slave (
        output start, continuous, dout,
        input  a, rd_addr, rd_data, rd_valid, busy, done, checksum
    );
`endif
endinterface

// File: rtl/mem_scan_reader.sv
// mem_scan_reader: sweeps a synchronous RAM from address 0 to DEPTH-1, holds
// each captured entry on rd_addr/rd_data for DWELL cycles and accumulates an
// 8-bit (DW-bit) checksum of the whole array. `a` is meaningful only while busy.
// Optional feature: define MEM_SCAN_READER_PAUSE_EN to add a `pause` input
// that freezes the dwell countdown while in HOLD.
module mem_scan_reader #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int DWELL = 25000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_scan_reader_if.master    bus
);
    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] a_q;
    logic [AW-1:0] rd_addr_q;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] checksum_q;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          hold_run;

`ifdef MEM_SCAN_READER_PAUSE_EN
    assign hold_run = ~bus.pause;
`else
    assign hold_run = 1'b1;
`endif

    assign bus.a        = a_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.checksum = checksum_q;

    // Sweep sequencer: issue address, capture RAM data, dwell, advance or finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_q        <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            checksum_q <= '0;
            acc        <= '0;
            cnt        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q        <= '0;
                        acc        <= '0;
                        rd_valid_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                // RAM registers mem[a] on this edge; dout is valid in CAPTURE.
                S_ISSUE: state <= S_CAPTURE;
                S_CAPTURE: begin
                    rd_data_q  <= bus.dout;
                    rd_addr_q  <= a_q;
                    rd_valid_q <= 1'b1;
                    acc        <= acc + bus.dout;
                    cnt        <= CW'(DWELL - 1);
                    state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_run) begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else if (a_q != LAST) begin
                            a_q   <= a_q + AW'(1);
                            state <= S_ISSUE;
                        end else begin
                            // acc already holds the last entry's contribution.
                            checksum_q <= acc;
                            done_q     <= 1'b1;
                            if (bus.continuous) begin
                                a_q   <= '0;
                                acc   <= '0;
                                state <= S_ISSUE;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= S_IDLE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
